// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: RV32I load/store width
// codes, responder FSM encoding and the byte-enable type.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [3:0] be_t;
endpackage

// File: rtl/ls_align.sv
// Byte-lane steering: store data replication with lane enables, and load
// byte/halfword extraction with sign or zero extension.
module ls_align
    import mem_pkg::*;
(
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output be_t         o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_be    = be_t'(4'b0001 << i_addr_lo);
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_rdata = 32'd0;
        case (i_funct3)
            F3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU: o_rdata = {24'd0, w_byte};
            F3_H:  o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU: o_rdata = {16'd0, w_half};
            F3_W:  o_rdata = i_word;
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word array, answering each
// accepted request after a fixed LATENCY with registered data and error flag.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [AW-1:0] w_idx;
    logic          w_f3_ok;
    logic          w_align_ok;
    logic          w_range_ok;
    logic          w_err;
    logic          w_accept;
    be_t           w_be;
    logic [31:0]   w_st_data;
    logic [31:0]   w_ld_data;

    assign w_idx      = req_addr[AW+1:2];
    assign w_range_ok = ((req_addr >> (AW + 2)) == 32'd0);
    assign w_err      = !(w_f3_ok && w_align_ok && w_range_ok);
    assign w_accept   = req_valid && req_ready;

    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b1;
        case (req_funct3)
            F3_B:         w_f3_ok = 1'b1;
            F3_BU:        w_f3_ok = !req_we;
            F3_H, F3_HU: begin
                w_f3_ok    = (req_funct3 == F3_H) || !req_we;
                w_align_ok = !req_addr[0];
            end
            F3_W: begin
                w_f3_ok    = 1'b1;
                w_align_ok = (req_addr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    ls_align u_align (
        .i_wdata   (req_wdata),
        .i_funct3  (req_funct3),
        .i_addr_lo (req_addr[1:0]),
        .i_word    (r_mem[w_idx]),
        .o_be      (w_be),
        .o_wdata   (w_st_data),
        .o_rdata   (w_ld_data)
    );

    // Array is deliberately unreset; a store commits on its own acceptance edge.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_err   <= w_err;
                        r_rdata <= (req_we || w_err) ? 32'd0 : w_ld_data;
                        if (LATENCY > 1) begin
                            r_state <= BUSY;
                            r_cnt   <= CW'((LATENCY > 1) ? LATENCY - 2 : 0);
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) r_state <= RESP;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                RESP: begin
                    if (rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Load/store responder for the RISC-V core's data memory. It accepts one request at a time from the core's memory stage over a valid/ready handshake, performs a byte, halfword or word access on an internal word array, and returns the load result or store acknowledge after a fixed programmable latency. On the core side, the load data it returns is the memory-data input of the writeback result select. Misaligned, out-of-range and illegal-width accesses are rejected with an error response.

## Interface
- DEPTH, 1024: number of 32-bit words in the array (power of two, ≥4)
- LATENCY, 2: cycles from request acceptance to rsp_valid (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for SB/SH)
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  access rejected

## Operation
- FSM states: IDLE, BUSY, RESP. Reset and return state: IDLE.
- req_ready = 1 only in IDLE (decoded from state, no combinational path from inputs).
- Acceptance: req_valid && req_ready on a rising edge. All request fields are captured at that edge.
- Error check at acceptance, any one sets err:
  - funct3 not in {000,001,010,100,101}, or store with funct3 ∉ {000,001,010}
  - H/HU with addr[0]=1; W with addr[1:0]≠00
  - addr[31:2] ≥ DEPTH
- Store without error: the selected byte lanes of word addr[31:2] are written at the acceptance edge. SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all four lanes. Other lanes are unchanged. An erroneous store writes nothing.
- Load without error: the word is read at the acceptance edge.
  - B/BU select the byte at addr[1:0]; H/HU select the halfword at addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Transitions:
  - IDLE→BUSY on acceptance if LATENCY>1, or IDLE→RESP if LATENCY=1.
  - BUSY decrements a counter and moves to RESP when it expires.
  - RESP→IDLE on rsp_valid && rsp_ready.
- rsp_rdata and rsp_err are registered. They stay stable while rsp_valid=1 and rsp_ready=0.
- Array contents are not reset.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- rsp_valid rises exactly LATENCY cycles after the acceptance edge.
- Throughput is at most one request per LATENCY+1 cycles with rsp_ready tied high. After the response handshake, req_ready returns the next cycle (no same-cycle re-accept).
- A load issued in the cycle after a store to the same word returns the stored data.
- Reset asserted mid-transaction: the pending response is dropped and no rsp_valid appears. A store already committed at its acceptance edge remains in the array.
- req_valid while busy: ignored. The core must hold the request until req_ready is high.

## Structure
- Package mem_pkg holds:
  - funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the FSM state encoding (IDLE/BUSY/RESP)
  - a 4-bit byte-enable type
- Sub-module ls_align is combinational. It does store lane merge (wdata, funct3, addr[1:0] → byte enables and shifted data) and load extract/extend (word, funct3, addr[1:0] → rdata).

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0. rsp_valid rises 2 cycles after each acceptance.
- After the above: SB addr 0x11 data 0x7F, then LW 0x10 → 0xDEAD7FEF. LB 0x13 → 0xFFFFFFDE. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDEAD.
- LW addr 0x12 → rsp_err 1, rsp_rdata 0. SH addr 0x11 data 0x1234 → rsp_err 1, and a subsequent LW 0x10 shows the word unchanged.
- Out of range: LW addr 4×DEPTH → rsp_err 1. funct3=011 load → rsp_err 1.
- Hold rsp_ready=0 for 5 cycles with rsp_valid=1: rsp_rdata and rsp_err are stable and req_ready=0. rsp_ready=1 completes the response, and req_ready=1 on the next cycle.
- Assert rst_n=0 during BUSY of a load: rsp_valid stays 0, and all outputs are at reset values while rst_n=0 and after release.
